// File: rtl/booth_r4_mult_param.sv
// booth_r4_mult_param
//   Radix-4 Booth sequential multiplier with WIDTH-bit operands and a
//   start/busy/done handshake. A runtime is_signed flag selects two's-complement
//   or unsigned operands. One multiply is in flight at a time. The product
//   register holds its value until the next accepted start.
//
//   Optional feature, selected by the macro BOOTH_R4_EARLY_TERM_EN:
//   when the macro is defined, the unit stops as soon as every remaining
//   recode is zero. When it is undefined, the latency is a fixed WIDTH/2+1 steps.
module booth_r4_mult_param #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // N steps consume the WIDTH+2-bit extended multiplier two bits at a time;
  // the extra step lets unsigned operands with MSB set come out exact.
  localparam int N   = WIDTH / 2 + 1;
  localparam int CW  = $clog2(N + 1);
  localparam int AW  = WIDTH + 3;       // accumulator / multiplicand width
  localparam int QW  = WIDTH + 2;       // extended multiplier width
  localparam int SW  = AW + QW + 1;     // {A, Q, q_m1}
  localparam int PW  = 2 * WIDTH;

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("booth_r4_mult_param: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [QW-1:0]   q_q, q_d;
  logic            qm1_q, qm1_d;
  logic [AW-1:0]   m_q, m_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;

  // Datapath intermediates
  logic [AW-1:0]   addend;
  logic [AW-1:0]   a_sum;
  logic [SW-1:0]   shifted;
  logic            last_step;
  logic            finish_step;
  logic [PW-1:0]   final_product;
  logic [QW-1:0]   q_ext;
  logic [AW-1:0]   m_ext;

  // Sign- or zero-extend the operands so that both modes share one signed datapath
  always_comb begin
    q_ext = {2'b00, multiplier};
    m_ext = {3'b000, multiplicand};
    if (is_signed) begin
      q_ext = {{2{multiplier[WIDTH-1]}}, multiplier};
      m_ext = {{3{multiplicand[WIDTH-1]}}, multiplicand};
    end
  end

  // Radix-4 Booth recode of {Q[1], Q[0], q_m1} into a signed multiple of M
  always_comb begin
    addend = '0;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: addend = m_q;
      3'b011:         addend = m_q << 1;
      3'b100:         addend = -(m_q << 1);
      3'b101, 3'b110: addend = -m_q;
      default:        addend = '0;
    endcase
  end

  // Add the recoded multiple and arithmetic-shift {A, Q, q_m1} right by two
  assign a_sum     = a_q + addend;
  assign shifted   = $signed({a_sum, q_q, qm1_q}) >>> 2;
  assign last_step = (cnt_q == CW'(1));

`ifdef BOOTH_R4_EARLY_TERM_EN
  // Early exit: after this step, 2*(cnt_q-1) multiplier bits remain
  // unconsumed in the low end of Q. When those bits and q_m1 all agree,
  // every remaining recode is zero. The remaining steps then reduce to a
  // pure arithmetic shift of {A, Q}.
  localparam int RBW = CW + 1;
  logic [CW-1:0]  rem_steps;
  logic [RBW-1:0] rem_bits;
  logic [QW-1:0]  bit_ok;
  logic [SW-2:0]  aq_shifted;
  logic           early_exit;

  assign rem_steps = cnt_q - CW'(1);
  assign rem_bits  = {rem_steps, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < QW; gi++) begin : g_rem_chk
      // Bit gi of the shifted Q is still unconsumed when gi < rem_bits
      assign bit_ok[gi] = (RBW'(gi) >= rem_bits) || (shifted[gi+1] == shifted[0]);
    end
  endgenerate

  assign early_exit    = &bit_ok;
  assign aq_shifted    = $signed(shifted[SW-1:1]) >>> rem_bits;
  assign finish_step   = last_step | early_exit;
  assign final_product = aq_shifted[PW-1:0];
`else
  // Fixed latency: the product is taken only on the last of N steps
  assign finish_step   = last_step;
  assign final_product = shifted[PW:1];
`endif

  // Next-state logic for the FSM and the datapath registers
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Accept: load operands and leave the product register untouched
          a_d     = '0;
          q_d     = q_ext;
          qm1_d   = 1'b0;
          m_d     = m_ext;
          cnt_d   = CW'(N);
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // start is ignored here; one Booth step per cycle
        a_d   = shifted[SW-1:QW+1];
        q_d   = shifted[QW:1];
        qm1_d = shifted[0];
        cnt_d = cnt_q - CW'(1);
        if (finish_step) begin
          product_d = final_product;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth_r4_mult_param.sv
// tb_booth_r4_mult_param
//   Scoreboard bench for booth_r4_mult_param at WIDTH=16. Expected products
//   are pushed when an op is driven and popped when done is seen.
`timescale 1ns/1ps
module tb_booth_r4_mult_param;

  localparam int W  = 16;
  localparam int N  = W / 2 + 1;
  localparam int PW = 2 * W;
`ifdef BOOTH_R4_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          is_signed = 1'b0;
  logic [W-1:0]  multiplicand = '0;
  logic [W-1:0]  multiplier = '0;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int tests_run = 0;
  int tests_failed = 0;
  logic [PW-1:0] sb_q[$];

  always #5 clk = ~clk;

  booth_r4_mult_param #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  // Reference: exact product of the extended operands, truncated to 2*W bits
  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    logic signed [W:0]     ea;
    logic signed [W:0]     eb;
    logic signed [2*W+1:0] p;
    ea = s ? $signed({a[W-1], a}) : $signed({1'b0, a});
    eb = s ? $signed({b[W-1], b}) : $signed({1'b0, b});
    p  = ea * eb;
    return p[PW-1:0];
  endfunction

  // Drive one op from idle, push its expectation, wait (bounded) for done
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int edges, output bit timed_out);
    int cyc;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    is_signed    = s;
    start        = 1'b1;
    sb_q.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    timed_out = 1'b1;
    while (cyc < 100) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    edges = cyc - 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_done: got %b expected 0", done);
    end
    tests_run++;
    if (product !== '0) begin
      tests_failed++; $display("FAIL reset_product: got %h expected 0", product);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_corners();
    logic [W-1:0]  ta [9] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h7FFF,
                              16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [W-1:0]  tb_ [9] = '{16'h8000, 16'hFFFF, 16'h0001, 16'h8000, 16'h8000,
                               16'h1234, 16'hFFFF, 16'h7FFF, 16'hFFFF};
    logic          ts [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [PW-1:0] tx [9] = '{32'h4000_0000, 32'hFFFE_0001, 32'hFFFF_FFFF, 32'h4000_0000,
                              32'hC000_8000, 32'h0000_0000, 32'h0000_0001, 32'h3FFF_0001,
                              32'h7FFF_8000};
    int edges;
    bit to;
    logic [PW-1:0] exp;
    for (int i = 0; i < 9; i++) begin
      run_op(ta[i], tb_[i], ts[i], edges, to);
      exp = sb_q.pop_front();
      $display("[TB] corner %0d a=%h b=%h s=%0d product=%h edges=%0d", i, ta[i], tb_[i],
               ts[i], product, edges);
      tests_run++;
      if (to) begin
        tests_failed++; $display("FAIL corner_timeout[%0d]: no done within 100 cycles", i);
      end else begin
        tests_run++;
        if (product !== tx[i]) begin
          tests_failed++;
          $display("FAIL corner_const[%0d]: got %h expected %h", i, product, tx[i]);
        end
        if (product !== exp) begin
          tests_failed++;
          $display("FAIL corner_model[%0d]: got %h expected %h", i, product, exp);
        end
        tests_run++;
        if (EARLY ? (edges < 1 || edges > N) : (edges != N)) begin
          tests_failed++;
          $display("FAIL corner_latency[%0d]: got %0d edges expected %0d", i, edges, N);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    int ndone;
    int first_edges;
    logic [PW-1:0] got;
    logic [PW-1:0] exp;
    @(negedge clk);
    multiplicand = 16'h1234;
    multiplier   = 16'h5678;
    is_signed    = 1'b1;
    start        = 1'b1;
    sb_q.push_back(model(16'h1234, 16'h5678, 1'b1));
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    ndone = 0;
    first_edges = -1;
    got = '0;
    for (int i = 0; i < 40; i++) begin
      if (cyc == 3) begin
        start        = 1'b1;
        multiplicand = 16'h1111;
        multiplier   = 16'h2222;
        is_signed    = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          got = product;
          first_edges = cyc - 1;
        end
      end
    end
    exp = sb_q.pop_front();
    $display("[TB] ignored-start op product=%h dones=%0d edges=%0d", got, ndone, first_edges);
    tests_run++;
    if (ndone !== 1) begin
      tests_failed++; $display("FAIL ignored_start_dones: got %0d expected 1", ndone);
    end
    tests_run++;
    if (got !== exp) begin
      tests_failed++; $display("FAIL ignored_start_product: got %h expected %h", got, exp);
    end
    tests_run++;
    if (product !== exp) begin
      tests_failed++; $display("FAIL product_hold: got %h expected %h", product, exp);
    end
  endtask

  task automatic test_async_reset();
    int ndone;
    int edges;
    bit to;
    logic [PW-1:0] exp;
    @(negedge clk);
    multiplicand = 16'h00FF;
    multiplier   = 16'h0F0F;
    is_signed    = 1'b1;
    start        = 1'b1;
    sb_q.push_back(model(16'h00FF, 16'h0F0F, 1'b1));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_reset_flags: got busy=%b done=%b expected 0 0", busy, done);
    end
    tests_run++;
    if (product !== '0) begin
      tests_failed++; $display("FAIL midrun_reset_product: got %h expected 0", product);
    end
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    tests_run++;
    if (ndone !== 0) begin
      tests_failed++; $display("FAIL aborted_done: got %0d pulses expected 0", ndone);
    end
    run_op(16'h0123, 16'hFEDC, 1'b1, edges, to);
    exp = sb_q.pop_front();
    $display("[TB] post-reset op product=%h edges=%0d", product, edges);
    tests_run++;
    if (to || product !== exp) begin
      tests_failed++;
      $display("FAIL post_reset_op: got %h (timeout=%0d) expected %h", product, to, exp);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit to;
    logic [PW-1:0] exp;
    @(negedge clk);
    multiplicand = 16'd7;
    multiplier   = 16'd6;
    is_signed    = 1'b1;
    start        = 1'b1;
    sb_q.push_back(model(16'd7, 16'd6, 1'b1));
    @(negedge clk);
    multiplicand = 16'd5;
    multiplier   = 16'hFFFD;
    sb_q.push_back(model(16'd5, 16'hFFFD, 1'b1));
    cyc = 1;
    to = 1'b1;
    while (cyc < 100) begin
      if (done) begin to = 1'b0; break; end
      @(negedge clk);
      cyc++;
    end
    exp = sb_q.pop_front();
    $display("[TB] b2b first product=%h edges=%0d", product, cyc - 1);
    tests_run++;
    if (to || product !== 32'd42 || product !== exp) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h (timeout=%0d) expected %h", product, to, 32'd42);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
    end
    start = 1'b0;
    cyc = 1;
    to = 1'b1;
    while (cyc < 100) begin
      if (done) begin to = 1'b0; break; end
      @(negedge clk);
      cyc++;
    end
    exp = sb_q.pop_front();
    $display("[TB] b2b second product=%h edges=%0d", product, cyc - 1);
    tests_run++;
    if (to || product !== 32'hFFFF_FFF1 || product !== exp) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h (timeout=%0d) expected %h", product, to, 32'hFFFF_FFF1);
    end
    tests_run++;
    if (EARLY ? (cyc - 1 < 1 || cyc - 1 > N) : (cyc - 1 != N)) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d edges expected %0d", cyc - 1, N);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] corner [6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8001};
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    int edges;
    bit to;
    logic [PW-1:0] exp;
    for (int i = 0; i < 250; i++) begin
      a = ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : W'($urandom);
      b = ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : W'($urandom);
      s = 1'($urandom_range(1));
      run_op(a, b, s, edges, to);
      exp = sb_q.pop_front();
      $display("[TB] rand %0d a=%h b=%h s=%0d product=%h edges=%0d", i, a, b, s, product, edges);
      tests_run++;
      if (to || product !== exp) begin
        tests_failed++;
        $display("FAIL rand_product[%0d]: got %h (timeout=%0d) expected %h", i, product, to, exp);
      end
      tests_run++;
      if (EARLY ? (edges < 1 || edges > N) : (edges != N)) begin
        tests_failed++;
        $display("FAIL rand_latency[%0d]: got %0d edges expected %0d", i, edges, N);
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
